// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: DCM reset/hold, lock wait with bounded retries,
// IDELAYCTRL reset, then a maskable per-channel IDELAY reset pulse.
module reset_seq_ctrl #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 24,
    parameter int DCM_HOLD     = 8500000,
    parameter int LOCK_TIMEOUT = 800000,
    parameter int CTRL_PW      = 3,
    parameter int SETTLE       = 10,
    parameter int IDLY_PW      = 1,
    parameter int MAX_RETRY    = 3
) (
    input  logic            clk40,
    input  logic            rst_n,
    input  logic            full_rst_trig,
    input  logic            idelay_rst_trig,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            dcm_locked,
    output logic            dcm_rst,
    output logic            idelayctrl_rst,
    output logic [N_CH-1:0] idelay_rst,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [1:0]      retry_cnt
);

    localparam int RET_W = (MAX_RETRY > 2) ? $clog2(MAX_RETRY + 1) : 2;

    localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(DCM_HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_END    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CTRL_END   = CNT_W'(CTRL_PW - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] IDLY_END   = CNT_W'(IDLY_PW - 1);
    localparam logic [RET_W-1:0] RET_MAX    = RET_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DCM_RST,
        S_WAIT_LOCK,
        S_CTRL_RST,
        S_SETTLE,
        S_IDLY_RST,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [RET_W-1:0] retries;
    logic [RET_W-1:0] retries_nxt;
    logic [N_CH-1:0]  mask;
    logic [N_CH-1:0]  mask_nxt;
    logic [1:0]       ret_sat;
    logic             restart;
    logic             lock_fail;

    always_comb begin
        state_nxt   = state;
        mask_nxt    = mask;
        retries_nxt = retries;
        restart     = 1'b0;
        lock_fail   = 1'b0;
        if (full_rst_trig) begin
            state_nxt   = S_DCM_RST;
            mask_nxt    = ch_mask;
            retries_nxt = '0;
            restart     = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (idelay_rst_trig) begin
                        state_nxt = S_IDLY_RST;
                        mask_nxt  = ch_mask;
                    end
                end
                S_DCM_RST: begin
                    if (cnt == HOLD_END) state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // lock seen in the timeout cycle still wins
                    if (dcm_locked) state_nxt = S_CTRL_RST;
                    else if (cnt == TMO_END) lock_fail = 1'b1;
                end
                S_CTRL_RST: begin
                    if (!dcm_locked) lock_fail = 1'b1;
                    else if (cnt == CTRL_END) state_nxt = S_SETTLE;
                end
                S_SETTLE: begin
                    if (!dcm_locked) lock_fail = 1'b1;
                    else if (cnt == SETTLE_END) state_nxt = S_IDLY_RST;
                end
                S_IDLY_RST: begin
                    if (!dcm_locked) lock_fail = 1'b1;
                    else if (cnt == IDLY_END) state_nxt = S_DONE;
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
            if (lock_fail) begin
                if (retries < RET_MAX) begin
                    retries_nxt = retries + 1'b1;
                    state_nxt   = S_DCM_RST;
                end else begin
                    state_nxt = S_FAULT;
                end
            end
        end
    end

    // counter only runs inside timed stages
    always_comb begin
        cnt_nxt = cnt + 1'b1;
        if (restart || state_nxt != state ||
            state_nxt == S_IDLE || state_nxt == S_FAULT) begin
            cnt_nxt = '0;
        end
    end

    if (RET_W > 2) begin : g_sat
        assign ret_sat = (|retries_nxt[RET_W-1:2]) ? 2'd3
                                                   : retries_nxt[1:0];
    end else begin : g_nosat
        assign ret_sat = retries_nxt[1:0];
    end

    always_ff @(posedge clk40) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            retries        <= '0;
            mask           <= '0;
            dcm_rst        <= 1'b0;
            idelayctrl_rst <= 1'b0;
            idelay_rst     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
            retry_cnt      <= 2'd0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            retries        <= retries_nxt;
            mask           <= mask_nxt;
            dcm_rst        <= (state_nxt == S_DCM_RST);
            idelayctrl_rst <= (state_nxt == S_CTRL_RST);
            idelay_rst     <= (state_nxt == S_IDLY_RST) ? mask_nxt : '0;
            busy           <= !(state_nxt == S_IDLE || state_nxt == S_FAULT);
            done           <= (state_nxt == S_DONE);
            fault          <= (state_nxt == S_FAULT);
            retry_cnt      <= ret_sat;
        end
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: directed scenarios then random
// triggers/lock/reset checked cycle by cycle against a phase model.
module tb_reset_seq_ctrl;

    localparam int N_CH         = 4;
    localparam int CNT_W        = 24;
    localparam int DCM_HOLD     = 20;
    localparam int LOCK_TIMEOUT = 8;
    localparam int CTRL_PW      = 3;
    localparam int SETTLE       = 4;
    localparam int IDLY_PW      = 2;
    localparam int MAX_RETRY    = 2;

    logic            clk40 = 1'b0;
    logic            rst_n;
    logic            full_rst_trig;
    logic            idelay_rst_trig;
    logic [N_CH-1:0] ch_mask;
    logic            dcm_locked;
    logic            dcm_rst;
    logic            idelayctrl_rst;
    logic [N_CH-1:0] idelay_rst;
    logic            busy;
    logic            done;
    logic            fault;
    logic [1:0]      retry_cnt;

    always #5 clk40 = ~clk40;

    reset_seq_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .DCM_HOLD(DCM_HOLD),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .CTRL_PW(CTRL_PW),
        .SETTLE(SETTLE), .IDLY_PW(IDLY_PW), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk40(clk40),
        .rst_n(rst_n),
        .full_rst_trig(full_rst_trig),
        .idelay_rst_trig(idelay_rst_trig),
        .ch_mask(ch_mask),
        .dcm_locked(dcm_locked),
        .dcm_rst(dcm_rst),
        .idelayctrl_rst(idelayctrl_rst),
        .idelay_rst(idelay_rst),
        .busy(busy),
        .done(done),
        .fault(fault),
        .retry_cnt(retry_cnt)
    );

    typedef struct packed {
        logic            dcm;
        logic            ctrl;
        logic [N_CH-1:0] idly;
        logic            busy;
        logic            done;
        logic            fault;
        logic [1:0]      retry;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    int   done_seen = 0;
    int   done_want = 0;

    // reference model: current phase plus cycles remaining in it
    typedef enum {M_IDLE, M_DCM, M_WAIT, M_CTRL, M_SETTLE,
                  M_IDLY, M_DONE, M_FAULT} phase_t;

    phase_t          ph = M_IDLE;
    int              left = 0;
    int              retries = 0;
    logic [N_CH-1:0] m_mask = '0;

    task automatic enter(input phase_t p, input int n);
        ph   = p;
        left = n;
    endtask

    task automatic lock_lost();
        if (retries < MAX_RETRY) begin
            retries++;
            enter(M_DCM, DCM_HOLD);
        end else begin
            enter(M_FAULT, 0);
        end
    endtask

    task automatic tick(input phase_t nxt, input int n);
        left--;
        if (left == 0) enter(nxt, n);
    endtask

    task automatic model_step(input logic r, input logic f, input logic i,
                              input logic [N_CH-1:0] cm, input logic lk);
        if (!r) begin
            enter(M_IDLE, 0);
            retries = 0;
            m_mask  = '0;
        end else if (f) begin
            enter(M_DCM, DCM_HOLD);
            retries = 0;
            m_mask  = cm;
        end else begin
            case (ph)
                M_IDLE: if (i) begin
                    enter(M_IDLY, IDLY_PW);
                    m_mask = cm;
                end
                M_DCM: tick(M_WAIT, LOCK_TIMEOUT);
                M_WAIT: begin
                    if (lk) enter(M_CTRL, CTRL_PW);
                    else begin
                        left--;
                        if (left == 0) lock_lost();
                    end
                end
                M_CTRL:   if (!lk) lock_lost(); else tick(M_SETTLE, SETTLE);
                M_SETTLE: if (!lk) lock_lost(); else tick(M_IDLY, IDLY_PW);
                M_IDLY:   if (!lk) lock_lost(); else tick(M_DONE, 1);
                M_DONE:   enter(M_IDLE, 0);
                default:  ;
            endcase
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.dcm   = (ph == M_DCM);
        o.ctrl  = (ph == M_CTRL);
        o.idly  = (ph == M_IDLY) ? m_mask : '0;
        o.busy  = !(ph == M_IDLE || ph == M_FAULT);
        o.done  = (ph == M_DONE);
        o.fault = (ph == M_FAULT);
        o.retry = (retries > 3) ? 2'd3 : 2'(retries);
        return o;
    endfunction

    function automatic logic [N_CH-1:0] rmask();
        logic [N_CH-1:0] v;
        v = N_CH'($urandom);
        return v;
    endfunction

    task automatic cyc(input logic r, input logic f, input logic i,
                       input logic [N_CH-1:0] cm, input logic lk);
        obs_t e;
        rst_n           = r;
        full_rst_trig   = f;
        idelay_rst_trig = i;
        ch_mask         = cm;
        dcm_locked      = lk;
        model_step(r, f, i, cm, lk);
        e = model_out();
        if (e.done) done_want++;
        exp_q.push_back(e);
        @(negedge clk40);
    endtask

    task automatic idle(input int n, input logic lk);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, rmask(), lk);
    endtask

    // monitor: compares every presented output vector with the queue head
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(posedge clk40);
            #1;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {dcm_rst, idelayctrl_rst, idelay_rst, busy,
                     done, fault, retry_cnt};
                if (g.done === 1'b1) done_seen++;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outs cyc=%0d got dcm=%b ctrl=%b idly=%b busy=%b done=%b fault=%b retry=%0d want dcm=%b ctrl=%b idly=%b busy=%b done=%b fault=%b retry=%0d",
                             cyc_no, g.dcm, g.ctrl, g.idly, g.busy, g.done,
                             g.fault, g.retry, e.dcm, e.ctrl, e.idly,
                             e.busy, e.done, e.fault, e.retry);
                end
            end
        end
    end

    initial begin
        logic lk;
        logic r;
        logic f;
        logic i;

        // reset with random trigger noise
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'($urandom), 1'($urandom), rmask(), 1'b1);

        // full sequence, lock 5 cycles after dcm_rst falls
        cyc(1'b1, 1'b1, 1'b0, 4'b1011, 1'b0);
        idle(24, 1'b0);
        idle(16, 1'b1);

        // IDELAY-only reset
        cyc(1'b1, 1'b0, 1'b1, 4'b0100, 1'b1);
        idle(6, 1'b1);

        // no lock ever: retries then fault; idelay trigger ignored
        cyc(1'b1, 1'b1, 1'b0, 4'b1111, 1'b0);
        idle(95, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'b0011, 1'b0);
        idle(5, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 4'b0110, 1'b1);
        idle(40, 1'b1);

        // both triggers; idelay trigger while busy; restart in IDLY_RST
        cyc(1'b1, 1'b1, 1'b1, 4'b1001, 1'b1);
        idle(4, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 4'b0110, 1'b1);
        idle(22, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 4'b0101, 1'b1);
        idle(40, 1'b1);

        // lock drop during SETTLE
        cyc(1'b1, 1'b1, 1'b0, 4'b1110, 1'b1);
        idle(24, 1'b1);
        idle(1, 1'b0);
        idle(40, 1'b1);

        // reset pulse mid DCM_RST
        cyc(1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
        idle(10, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        idle(30, 1'b1);

        // random traffic
        lk = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if (lk) lk = ($urandom_range(0, 79) != 0);
            else    lk = ($urandom_range(0, 14) == 0);
            r = ($urandom_range(0, 399) != 0);
            f = ($urandom_range(0, 149) == 0);
            i = ($urandom_range(0, 19) == 0);
            cyc(r, f, i, rmask(), lk);
        end

        @(negedge clk40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0 pending", exp_q.size());
        end
        checks++;
        if (done_seen != done_want) begin
            errors++;
            $display("FAIL done_count got=%0d want=%0d", done_seen, done_want);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
Parametrised reset sequencer, clocked by the 40MHz system clock. On a trigger it runs up to three stages in order: DCM reset with a post-reset hold, a wait for DCM lock with a timeout and bounded retries, and an IDELAYCTRL reset. It then issues a per-channel, maskable IDELAY reset pulse. It drives the DCM, the IDELAYCTRL and N_CH IDELAY groups, and reports busy/done/fault status to the control register block.

Parameters:
N_CH, 4, number of independent IDELAY reset channels (1..32)
CNT_W, 24, stage counter width; must hold the largest cycle-count parameter
DCM_HOLD, 8500000, cycles dcm_rst is held high (212.5ms at 40MHz)
LOCK_TIMEOUT, 800000, cycles to wait for dcm_locked after dcm_rst falls (20ms)
CTRL_PW, 3, cycles idelayctrl_rst is high (>=2, i.e. >=50ns)
SETTLE, 10, idle cycles between idelayctrl_rst falling and idelay_rst rising
IDLY_PW, 1, cycles idelay_rst is high
MAX_RETRY, 3, DCM reset attempts allowed after the first before fault

Ports:
clk40  in  1  40MHz clock; all logic on its rising edge
rst_n  in  1  synchronous active-low reset
full_rst_trig  in  1  one-cycle pulse; start the full sequence
idelay_rst_trig  in  1  one-cycle pulse; IDELAY-only reset
ch_mask  in  N_CH  channel enable, captured when a trigger is accepted
dcm_locked  in  1  DCM LOCKED, already synchronous to clk40
dcm_rst  out  1  DCM reset
idelayctrl_rst  out  1  IDELAYCTRL reset
idelay_rst  out  N_CH  per-channel IDELAY reset
busy  out  1  high whenever the state is not IDLE or FAULT
done  out  1  one-cycle pulse when a sequence completes
fault  out  1  sticky: lock was never achieved within the allowed retries
retry_cnt  out  2  number of DCM retries used in the current or last sequence (saturating)

Behaviour:
- All outputs are registered.
- While rst_n=0 at an edge: state=IDLE, counter=0, retry_cnt=0, captured mask=0, and every output is 0.
- States: IDLE, DCM_RST, WAIT_LOCK, CTRL_RST, SETTLE, IDLY_RST, DONE, FAULT.
- Trigger accepted at edge k: the next state and its output are visible after edge k. Example: dcm_rst is high from edge k onward.
- IDLE:
  - full_rst_trig -> DCM_RST; capture ch_mask; clear retry_cnt and counter.
  - Otherwise idelay_rst_trig -> IDLY_RST; capture ch_mask.
  - Both triggers in the same cycle: full wins.
  - A trigger with ch_mask=0 is still accepted. In that case idelay_rst stays 0 but the timing and the done pulse are unchanged.
- DCM_RST: dcm_rst=1 for exactly DCM_HOLD cycles, then -> WAIT_LOCK with dcm_rst=0.
- WAIT_LOCK:
  - dcm_locked=1 -> CTRL_RST.
  - After LOCK_TIMEOUT cycles without lock:
    - retry_cnt<MAX_RETRY: increment retry_cnt, -> DCM_RST.
    - Otherwise -> FAULT.
  - Lock arriving in the timeout cycle itself counts as locked.
- CTRL_RST: idelayctrl_rst=1 for exactly CTRL_PW cycles -> SETTLE.
- SETTLE: all resets low for SETTLE cycles -> IDLY_RST.
- IDLY_RST: idelay_rst = captured mask for exactly IDLY_PW cycles -> DONE.
- DONE: done=1 for one cycle -> IDLE. The next trigger can be accepted in the cycle after done.
- FAULT:
  - fault=1 and all resets 0.
  - idelay_rst_trig is ignored.
  - full_rst_trig clears fault and restarts at DCM_RST with retry_cnt=0.
  - rst_n also clears fault.
- Lock loss in CTRL_RST, SETTLE or IDLY_RST: treated as a timeout (retry or FAULT) on the next edge. Any active pulse is cut short.
- Triggers while busy:
  - full_rst_trig aborts and restarts at DCM_RST from any state, including IDLY_RST. It clears retry_cnt and recaptures ch_mask.
  - idelay_rst_trig is ignored while busy.
- Counter: CNT_W bits, cleared on every state change. A stage ends when counter == PARAM-1. No wrap occurs within a legal configuration.
- rst_n low mid-sequence: all outputs drop on that edge and the sequence is abandoned; no done pulse is issued.
- retry_cnt saturates at 3.

Test Plan:
- Parameters for the bench: DCM_HOLD=20, LOCK_TIMEOUT=8, CTRL_PW=3, SETTLE=4, IDLY_PW=2, N_CH=4, MAX_RETRY=2.
- Full reset, ch_mask=4'b1011, lock 5 cycles after dcm_rst falls -> dcm_rst high exactly 20 cycles; idelayctrl_rst high 3 cycles after lock; 4 idle cycles; idelay_rst=4'b1011 for 2 cycles; done pulses once; retry_cnt=0.
- idelay_rst_trig in IDLE with ch_mask=4'b0100 -> idelay_rst=4'b0100 for 2 cycles on the next edge; dcm_rst and idelayctrl_rst stay 0; done 2 cycles after the trigger edge.
- dcm_locked held 0 -> three dcm_rst pulses of 20 cycles each, separated by 8-cycle waits; retry_cnt ends at 2; fault=1; busy=0. A following idelay_rst_trig is ignored; full_rst_trig clears fault.
- Both triggers in the same IDLE cycle -> full sequence runs. idelay_rst_trig during DCM_RST -> no effect. full_rst_trig during IDLY_RST -> idelay_rst drops and dcm_rst rises on the same edge.
- dcm_locked drops during SETTLE -> next edge enters DCM_RST and retry_cnt increments.
- rst_n=0 for one cycle mid DCM_RST -> all outputs 0 on that edge, state IDLE, no done pulse.
